// File: rtl/clock_gate_ctrl_if.sv
// Handshake bundle for the clock gate controller: per-channel requests and
// divide selects in, acknowledges, gated clocks and state visibility out.
interface clock_gate_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 4
);
  logic [NUM_CH-1:0]       ch_req;
  logic [NUM_CH*DIV_W-1:0] div_sel;
  logic                    test_en;
  logic [NUM_CH-1:0]       ch_ack;
  logic [NUM_CH-1:0]       clk_out;
  logic [2*NUM_CH-1:0]     ch_state;
  logic                    busy;

  modport master (
    output ch_req, div_sel, test_en,
    input  ch_ack, clk_out, ch_state, busy
  );

  modport slave (
    input  ch_req, div_sel, test_en,
    output ch_ack, clk_out, ch_state, busy
  );
endinterface

// File: rtl/clock_gate_ctrl.sv
// Multi-channel clock gate: each channel wakes on request, produces a
// pulse-swallowed clock through a glitch-free latch gate, and drains before off.
module clock_gate_ctrl #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 4,
  parameter int WAKE_CYC  = 2,
  parameter int DRAIN_CYC = 4
) (
  input logic              clk_in,
  input logic              rst_n,
  clock_gate_ctrl_if.slave bus
);

  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_WAKE  = 2'b01;
  localparam logic [1:0] ST_ON    = 2'b10;
  localparam logic [1:0] ST_DRAIN = 2'b11;

  localparam logic [7:0] WAKE_LOAD  = 8'(WAKE_CYC - 1);
  localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYC - 1);

  logic [1:0]          run_sync;
  logic                run;
  logic [NUM_CH-1:0]   en_raw;
  logic [NUM_CH-1:0]   ack_vec;
  logic [NUM_CH-1:0]   busy_nx;
  logic [NUM_CH-1:0]   gate_lat;
  logic [2*NUM_CH-1:0] state_vec;
  logic                busy_q;

  // Reset release is resynchronised so no FSM moves before the second edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      run_sync <= 2'b00;
    end else begin
      run_sync <= {run_sync[0], 1'b1};
    end
  end

  assign run = run_sync[1];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       state_q, state_d;
    logic [7:0]       timer_q, timer_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] dr_q, dr_d;
    logic             ack_q, ack_d;
    logic [DIV_W-1:0] div_i;
    logic             req;
    logic             running;
    logic             wrap;

    assign div_i   = bus.div_sel[i*DIV_W +: DIV_W];
    assign req     = bus.ch_req[i];
    assign running = (state_q == ST_ON) || (state_q == ST_DRAIN);
    assign wrap    = running && (cnt_q == dr_q);

    // The divider keeps running through DRAIN so a re-request resumes seamlessly.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      cnt_d   = cnt_q;
      dr_d    = dr_q;
      ack_d   = ack_q;
      if (running) begin
        if (wrap) begin
          cnt_d = '0;
          dr_d  = div_i;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      case (state_q)
        ST_OFF: begin
          if (req) begin
            state_d = ST_WAKE;
            timer_d = WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          if (!req) begin
            state_d = ST_OFF;
          end else if (timer_q == 8'd0) begin
            state_d = ST_ON;
            ack_d   = 1'b1;
            cnt_d   = '0;
            dr_d    = div_i;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        ST_ON: begin
          if (!req) begin
            state_d = ST_DRAIN;
            timer_d = DRAIN_LOAD;
          end
        end
        default: begin
          if (req) begin
            state_d = ST_ON;
          end else if (timer_q == 8'd0) begin
            state_d = ST_OFF;
            ack_d   = 1'b0;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= ST_OFF;
        timer_q <= '0;
        cnt_q   <= '0;
        dr_q    <= '0;
        ack_q   <= 1'b0;
      end else if (run) begin
        state_q <= state_d;
        timer_q <= timer_d;
        cnt_q   <= cnt_d;
        dr_q    <= dr_d;
        ack_q   <= ack_d;
      end
    end

    assign en_raw[i]            = wrap;
    assign ack_vec[i]           = ack_q;
    assign busy_nx[i]           = (state_d != ST_OFF);
    assign state_vec[2*i +: 2]  = state_q;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
    end else if (run) begin
      busy_q <= |busy_nx;
    end
  end

  // Gate enable only changes while clk_in is low, so the AND below cannot glitch.
  always_latch begin
    if (!rst_n) begin
      gate_lat <= '0;
    end else if (!clk_in) begin
      gate_lat <= en_raw | {NUM_CH{bus.test_en}};
    end
  end

  // test_en also bypasses the latch so scan clocks still run while in reset.
  assign bus.clk_out  = {NUM_CH{clk_in}} & (gate_lat | {NUM_CH{bus.test_en}});
  assign bus.ch_ack   = ack_vec;
  assign bus.ch_state = state_vec;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Testbench for clock_gate_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_clock_gate_ctrl;

  localparam int NUM_CH    = 4;
  localparam int DIV_W     = 4;
  localparam int WAKE_CYC  = 2;
  localparam int DRAIN_CYC = 4;

  localparam int M_OFF   = 0;
  localparam int M_WAKE  = 1;
  localparam int M_ON    = 2;
  localparam int M_DRAIN = 3;

  logic clk_in;
  logic rst_n;
  int   check_count = 0;
  int   pass_count  = 0;

  clock_gate_ctrl_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  clock_gate_ctrl #(
    .NUM_CH   (NUM_CH),
    .DIV_W    (DIV_W),
    .WAKE_CYC (WAKE_CYC),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk_in(clk_in),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_CH-1:0] req,
                               input logic [NUM_CH*DIV_W-1:0] div,
                               input logic ten, input logic rstn);
    bus.ch_req  = req;
    bus.div_sel = div;
    bus.test_en = ten;
    rst_n       = rstn;
  endtask

  task automatic toHigh();
    @(posedge clk_in);
    #2;
  endtask

  task automatic toLow();
    #4;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #6;
    end
  endtask

  // Behavioural model: channel lifecycle with a running period count.
  int               m_state [NUM_CH];
  int               m_timer [NUM_CH];
  int               m_cnt   [NUM_CH];
  int               m_div   [NUM_CH];
  logic [NUM_CH-1:0] m_pulse = '0;

  initial begin
    for (int i = 0; i < NUM_CH; i++) begin
      m_state[i] = M_OFF;
      m_timer[i] = 0;
      m_cnt[i]   = 0;
      m_div[i]   = 0;
    end
  end

  always @(posedge clk_in) begin : model_blk
    logic [2*NUM_CH-1:0] exp_state;
    logic [NUM_CH-1:0]   exp_ack;
    logic [NUM_CH-1:0]   exp_clk;
    int                  d_in;
    bit                  req;
    bit                  running;
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_state[i] = M_OFF;
        m_timer[i] = 0;
        m_cnt[i]   = 0;
        m_div[i]   = 0;
      end
      m_pulse = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        d_in       = int'(bus.div_sel[i*DIV_W +: DIV_W]);
        req        = bus.ch_req[i];
        running    = (m_state[i] == M_ON) || (m_state[i] == M_DRAIN);
        m_pulse[i] = running && (m_cnt[i] == m_div[i]);
        if (running) begin
          if (m_pulse[i]) begin
            m_cnt[i] = 0;
            m_div[i] = d_in;
          end else begin
            m_cnt[i]++;
          end
        end
        case (m_state[i])
          M_OFF: if (req) begin
            m_state[i] = M_WAKE;
            m_timer[i] = WAKE_CYC - 1;
          end
          M_WAKE: if (!req) m_state[i] = M_OFF;
            else if (m_timer[i] == 0) begin
              m_state[i] = M_ON;
              m_cnt[i]   = 0;
              m_div[i]   = d_in;
            end else m_timer[i]--;
          M_ON: if (!req) begin
            m_state[i] = M_DRAIN;
            m_timer[i] = DRAIN_CYC - 1;
          end
          default: if (req) m_state[i] = M_ON;
            else if (m_timer[i] == 0) m_state[i] = M_OFF;
            else m_timer[i]--;
        endcase
      end
    end
    #2;
    for (int i = 0; i < NUM_CH; i++) begin
      exp_state[2*i +: 2] = 2'(m_state[i]);
      exp_ack[i]          = (m_state[i] == M_ON) || (m_state[i] == M_DRAIN);
    end
    exp_clk = m_pulse | {NUM_CH{bus.test_en}};
    checkOutput("model_state", 32'(bus.ch_state), 32'(exp_state));
    checkOutput("model_ack", 32'(bus.ch_ack), 32'(exp_ack));
    checkOutput("model_busy", 32'(bus.busy), 32'(exp_state != '0));
    checkOutput("model_clk_out", 32'(bus.clk_out), 32'(exp_clk));
  end

  int pulse_cnt [NUM_CH];
  int pulse_at [$];

  task automatic collectPulses(input int n);
    for (int i = 0; i < NUM_CH; i++) pulse_cnt[i] = 0;
    pulse_at.delete();
    for (int k = 0; k < n; k++) begin
      toHigh();
      for (int i = 0; i < NUM_CH; i++) if (bus.clk_out[i]) pulse_cnt[i]++;
      if (bus.clk_out[0]) pulse_at.push_back(k);
      toLow();
    end
  endtask

  task automatic waitPulse(output bit found);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      toHigh();
      if (bus.clk_out[0]) found = 1'b1;
      toLow();
    end
  endtask

  initial begin : stim
    bit found;
    int bad_gaps;
    int holdoff;
    int exp_rel [5];
    exp_rel = '{8, 10, 12, 14, 16};

    applyStimulus('0, '0, 1'b0, 1'b0);
    tick(3);

    // Reset state, then test mode forcing the gates open.
    toHigh();
    checkOutput("rst_clk_out", 32'(bus.clk_out), 32'h0);
    checkOutput("rst_ack", 32'(bus.ch_ack), 32'h0);
    checkOutput("rst_state", 32'(bus.ch_state), 32'h0);
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    toLow();
    bus.test_en = 1'b1;
    toHigh();
    checkOutput("test_clk_high", 32'(bus.clk_out), 32'hF);
    toLow();
    checkOutput("test_clk_low", 32'(bus.clk_out), 32'h0);
    checkOutput("test_ack", 32'(bus.ch_ack), 32'h0);
    bus.test_en = 1'b0;
    rst_n = 1'b1;
    tick(4);

    // Wake-up latency.
    bus.div_sel[3:0] = 4'd3;
    bus.ch_req[0] = 1'b1;
    toHigh();
    checkOutput("wake_state_n", 32'(bus.ch_state[1:0]), 32'd1);
    checkOutput("wake_busy_n", 32'(bus.busy), 32'd1);
    checkOutput("wake_ack_n", 32'(bus.ch_ack[0]), 32'd0);
    toLow();
    toHigh();
    checkOutput("wake_state_n1", 32'(bus.ch_state[1:0]), 32'd1);
    checkOutput("wake_ack_n1", 32'(bus.ch_ack[0]), 32'd0);
    toLow();
    toHigh();
    checkOutput("on_state_n2", 32'(bus.ch_state[1:0]), 32'd2);
    checkOutput("on_ack_n2", 32'(bus.ch_ack[0]), 32'd1);
    toLow();

    // Divide by 4.
    collectPulses(20);
    checkOutput("div3_count", 32'(pulse_cnt[0]), 32'd5);
    bad_gaps = 0;
    for (int k = 1; k < pulse_at.size(); k++)
      if (pulse_at[k] - pulse_at[k-1] != 4) bad_gaps++;
    checkOutput("div3_gaps", 32'(bad_gaps), 32'd0);
    checkOutput("div3_others", 32'(pulse_cnt[1] + pulse_cnt[2] + pulse_cnt[3]), 32'd0);

    // Divide change mid-period lands on the boundary.
    bus.div_sel[3:0] = 4'd7;
    waitPulse(found);
    checkOutput("div7_seen", 32'(found), 32'd1);
    pulse_at.delete();
    for (int r = 1; r <= 16; r++) begin
      toHigh();
      if (bus.clk_out[0]) pulse_at.push_back(r);
      toLow();
      if (r == 3) bus.div_sel[3:0] = 4'd1;
    end
    checkOutput("div_change_count", 32'(pulse_at.size()), 32'd5);
    for (int k = 0; k < 5 && k < pulse_at.size(); k++)
      checkOutput("div_change_time", 32'(pulse_at[k]), 32'(exp_rel[k]));

    // Drain with d=0.
    bus.div_sel[3:0] = 4'd0;
    waitPulse(found);
    checkOutput("div0_seen", 32'(found), 32'd1);
    bus.ch_req[0] = 1'b0;
    toHigh();
    checkOutput("drain_state_m", 32'(bus.ch_state[1:0]), 32'd3);
    checkOutput("drain_ack_m", 32'(bus.ch_ack[0]), 32'd1);
    toLow();
    for (int k = 1; k <= 4; k++) begin
      toHigh();
      checkOutput("drain_pulse", 32'(bus.clk_out[0]), 32'd1);
      checkOutput("drain_state", 32'(bus.ch_state[1:0]), (k == 4) ? 32'd0 : 32'd3);
      checkOutput("drain_ack", 32'(bus.ch_ack[0]), (k == 4) ? 32'd0 : 32'd1);
      toLow();
    end
    for (int k = 0; k < 2; k++) begin
      toHigh();
      checkOutput("off_no_pulse", 32'(bus.clk_out[0]), 32'd0);
      toLow();
    end

    // Re-request during drain.
    bus.ch_req[0] = 1'b1;
    tick(4);
    bus.ch_req[0] = 1'b0;
    toHigh();
    checkOutput("rereq_state_m", 32'(bus.ch_state[1:0]), 32'd3);
    toLow();
    toHigh();
    checkOutput("rereq_ack_m1", 32'(bus.ch_ack[0]), 32'd1);
    toLow();
    bus.ch_req[0] = 1'b1;
    toHigh();
    checkOutput("rereq_state_m2", 32'(bus.ch_state[1:0]), 32'd2);
    checkOutput("rereq_ack_m2", 32'(bus.ch_ack[0]), 32'd1);
    checkOutput("rereq_pulse_m2", 32'(bus.clk_out[0]), 32'd1);
    toLow();

    // One-cycle request on channel 1 aborts in WAKE.
    bus.ch_req[1] = 1'b1;
    toHigh();
    checkOutput("short_state_p", 32'(bus.ch_state[3:2]), 32'd1);
    checkOutput("short_clk_p", 32'(bus.clk_out[1]), 32'd0);
    toLow();
    bus.ch_req[1] = 1'b0;
    toHigh();
    checkOutput("short_state_p1", 32'(bus.ch_state[3:2]), 32'd0);
    checkOutput("short_ack_p1", 32'(bus.ch_ack[1]), 32'd0);
    toLow();
    collectPulses(4);
    checkOutput("short_no_pulse", 32'(pulse_cnt[1]), 32'd0);

    // Reset in the high phase kills the gated clock at once.
    toHigh();
    checkOutput("prerst_clk", 32'(bus.clk_out[0]), 32'd1);
    #1;
    rst_n = 1'b0;
    bus.ch_req = '0;
    #1;
    checkOutput("midrst_clk", 32'(bus.clk_out), 32'h0);
    checkOutput("midrst_state", 32'(bus.ch_state), 32'h0);
    checkOutput("midrst_ack", 32'(bus.ch_ack), 32'h0);
    #2;
    tick(2);
    rst_n = 1'b1;
    tick(3);

    // Randomized traffic against the model.
    holdoff = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!rst_n) begin
        rst_n   = 1'b1;
        holdoff = 3;
      end else if ($urandom_range(0, 149) == 0) begin
        rst_n      = 1'b0;
        bus.ch_req = '0;
      end
      if (holdoff > 0) begin
        bus.ch_req = '0;
        holdoff--;
      end else if (rst_n) begin
        for (int i = 0; i < NUM_CH; i++)
          if ($urandom_range(0, 7) == 0) bus.ch_req[i] = ~bus.ch_req[i];
      end
      if ($urandom_range(0, 9) == 0) bus.div_sel = 16'($urandom);
      bus.test_en = ($urandom_range(0, 19) == 0);
      tick(1);
    end

    bus.test_en = 1'b0;
    tick(2);
    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
